ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 device-to-host receiver that turns the raw keyboard `ps2_clk`/`ps2_data` lines into validated 8-bit scan codes. It sits between the board pins and the scan-code-to-ASCII translator, driving that stage's `in[7:0]` and `new_in` inputs. It synchronises and deglitches the bus and frames the 11-bit packet. It checks odd parity and the stop bit, and recovers from stalled frames with a watchdog.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive identical samples required before the filtered `ps2_clk` level changes (>= 2).
- `TIMEOUT`, 50000: clk cycles without a filtered `ps2_clk` edge before an in-progress frame is abandoned (1 ms at 50 MHz).

Ports:
- `clk`, input, 1: system clock; single clock domain.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ps2_clk`, input, 1: raw PS/2 clock pin, asynchronous.
- `ps2_data`, input, 1: raw PS/2 data pin, asynchronous.
- `code`, output, 8: last valid scan code; held until the next valid frame.
- `new_code`, output, 1: one-cycle pulse when `code` has just been updated.
- `parity_err`, output, 1: one-cycle pulse when a frame fails the odd-parity check.
- `frame_err`, output, 1: one-cycle pulse on a bad stop bit or a watchdog timeout.

## Operation
Input conditioning:
- Both pins pass through a 2-flop synchroniser. The flops reset to 1 (idle bus).
- Clock filter: `filt_clk` resets to 1. A counter of width clog2(FILTER_LEN+1) increments while the synchronised `ps2_clk` differs from `filt_clk`. It clears to 0 whenever they match. When the counter reaches FILTER_LEN, `filt_clk` toggles and the counter clears.
- A fall is `filt_clk`==0 with `filt_prev`==1. `filt_prev` is a registered copy of `filt_clk` and resets to 1.
- Data is the synchronised `ps2_data` sampled in the fall cycle. Data is not filtered.

Frame FSM (advances only on a fall):
- IDLE: if data==0 (start bit), go to DATA and clear the bit count. If data==1, stay in IDLE with no error.
- DATA: shift LSB first, `shreg <= {data, shreg[7:1]}`. After the 8th bit (count 7), go to PARITY.
- PARITY: `par_ok <= ^{shreg, data}`, which is 1 for odd parity. Go to STOP.
- STOP:
  - data==1 and `par_ok`: `code <= shreg`, pulse `new_code`.
  - data==1 and !`par_ok`: pulse `parity_err`; `code` is unchanged.
  - data==0: pulse `frame_err`; `code` is unchanged. This has priority over the parity result.
  - All three cases return to IDLE.

Watchdog:
- The counter clears on any filtered edge (rise or fall) and in IDLE. Otherwise it increments and saturates.
- Outside IDLE, when the counter reaches TIMEOUT the FSM goes to IDLE and `frame_err` pulses once. The watchdog is inactive in IDLE.
- A fall in the same cycle as a timeout is discarded.

Error pulses:
- At most one of `new_code`/`parity_err`/`frame_err` is high in any cycle.

Reset (asynchronous, `rst_n`=0):
- Outputs: `code`=0x00, `new_code`=0, `parity_err`=0, `frame_err`=0.
- State: FSM in IDLE; `shreg`, bit count, filter counter and watchdog all 0.
- Reset mid-frame drops the partial frame silently. The next start bit after release begins a fresh frame.

## Timing
- Latency: let edge 1 be the first rising `clk` edge at which the raw `ps2_clk` is low for the stop-bit fall. `filt_clk` falls at edge FILTER_LEN+2. `new_code`/`parity_err`/`frame_err` are high for exactly the cycle after edge FILTER_LEN+3.
- `code` changes on the same edge that raises `new_code` and is stable at least until the next frame completes. The downstream stage may use either the pulse or its rising edge.
- A glitch on `ps2_clk` shorter than FILTER_LEN samples produces no edge.
- No back-pressure: frames arrive at most every ~0.6 ms, so the consumer must take the pulse in the cycle it occurs.
- Throughput: one code per 11 PS/2 clocks.

## Test plan
- Clean frame 0x1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz, FILTER_LEN=8 -> exactly one `new_code` pulse, `code`=0x1C, no error pulses, latency FILTER_LEN+3 cycles from the stop-bit fall.
- Back-to-back frames 0xF0 then 0x1C -> two `new_code` pulses, `code`=0xF0 then 0x1C.
- Frame 0x5A with parity bit flipped -> one `parity_err` pulse, no `new_code`, `code` keeps its previous value (0x1C).
- Frame 0x29 with stop bit 0 -> one `frame_err` pulse, no `new_code`, `code` unchanged.
- Low glitch on `ps2_clk` of FILTER_LEN-1 cycles injected mid-frame of 0x76 -> ignored, `code`=0x76; the same glitch at FILTER_LEN cycles corrupts the frame (error pulse or desync resolved by the watchdog).
- Frame stalled after 4 data bits for TIMEOUT+10 cycles -> single `frame_err`, FSM in IDLE; a following clean 0x5A frame gives `code`=0x5A. Separately, `rst_n` pulsed low mid-frame -> all outputs 0, next clean frame decodes correctly.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync + deglitch pins, frame 11-bit packets, check odd parity/stop, watchdog.
// Latency FILTER_LEN+3 clk from stop-bit clock fall to pulse; no back-pressure, pulses are single-cycle.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       new_code,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic [WW-1:0] wd_cnt;
    logic          fall, any_edge, timeout, data;

    state_t        state, state_nx;
    logic [7:0]    shreg, shreg_nx, code_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic          par_ok, par_ok_nx;
    logic          new_nx, perr_nx, ferr_nx;

    // Synchronisers idle high so reset looks like an idle bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // filt_clk flips on the FILTER_LEN-th consecutive differing sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= ~filt_clk;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall     = filt_prev & ~filt_clk;
    assign any_edge = filt_prev ^ filt_clk;
    assign data     = data_sync[1];
    assign timeout  = (state != S_IDLE) && (wd_cnt == WW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state == S_IDLE || any_edge)
            wd_cnt <= '0;
        else if (wd_cnt != WW'(TIMEOUT))
            wd_cnt <= wd_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_ok     <= 1'b0;
            code       <= '0;
            new_code   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            bit_cnt    <= bit_cnt_nx;
            par_ok     <= par_ok_nx;
            code       <= code_nx;
            new_code   <= new_nx;
            parity_err <= perr_nx;
            frame_err  <= ferr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        par_ok_nx  = par_ok;
        code_nx    = code;
        new_nx     = 1'b0;
        perr_nx    = 1'b0;
        ferr_nx    = 1'b0;
        // A timeout wins over a coincident fall, which is dropped
        if (timeout) begin
            state_nx = S_IDLE;
            ferr_nx  = 1'b1;
        end else if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!data) begin
                        state_nx   = S_DATA;
                        bit_cnt_nx = '0;
                    end
                end
                S_DATA: begin
                    shreg_nx   = {data, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nx = S_PARITY;
                end
                S_PARITY: begin
                    par_ok_nx = ^{shreg, data};
                    state_nx  = S_STOP;
                end
                S_STOP: begin
                    state_nx = S_IDLE;
                    if (!data) begin
                        ferr_nx = 1'b1;
                    end else if (par_ok) begin
                        code_nx = shreg;
                        new_nx  = 1'b1;
                    end else begin
                        perr_nx = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed + randomized bench for ps2_rx: frames built from a byte, expected outcome from PS/2 framing rules.
module tb_ps2_rx;

    localparam int FL = 8;
    localparam int TO = 1000;
    localparam int H  = 48;   // PS/2 clock low time in clk cycles
    localparam int Q  = 24;   // data setup / hold around each PS/2 clock pulse

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       new_code, parity_err, frame_err;

    int n_cmp = 0, n_bad = 0;
    int cnt_new = 0, cnt_perr = 0, cnt_ferr = 0;
    logic [7:0] exp_code = 8'h00;

    always #5 clk = ~clk;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code(code), .new_code(new_code), .parity_err(parity_err), .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: tallies each pulse once and checks they never overlap
    always @(negedge clk) begin
        if (rst_n && (new_code || parity_err || frame_err)) begin
            cnt_new  = cnt_new  + int'(new_code);
            cnt_perr = cnt_perr + int'(parity_err);
            cnt_ferr = cnt_ferr + int'(frame_err);
            chk("onehot", 32'($countones({new_code, parity_err, frame_err})), 32'd1);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives the first nbits of a device-to-host frame; optional extra low glitch after bit 3
    task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop,
                              input int glitch, input int nbits, input bit chk_lat);
        logic [10:0] bits;
        logic [2:0]  kind;
        bits = {stop, ~^d ^ flip, d, 1'b0};
        kind = !stop ? 3'b001 : (flip ? 3'b010 : 3'b100);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(Q);
            ps2_clk = 1'b0;
            if (i == 10 && chk_lat) begin
                for (int k = 1; k <= H; k++) begin
                    @(posedge clk);
                    #1;
                    if (k == FL + 2) chk("lat_pre", 32'({new_code, parity_err, frame_err}), 32'd0);
                    if (k == FL + 3) chk("lat_pulse", 32'({new_code, parity_err, frame_err}), 32'(kind));
                end
                @(negedge clk);
            end else begin
                wait_cyc(H);
            end
            ps2_clk = 1'b1;
            wait_cyc(Q);
            if (glitch > 0 && i == 3) begin
                ps2_clk = 1'b0;
                wait_cyc(glitch);
                ps2_clk = 1'b1;
                wait_cyc(Q);
            end
        end
        ps2_data = 1'b1;
        wait_cyc(Q);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit flip, input bit stop,
                             input int glitch, input string tag);
        int n0, p0, f0;
        n0 = cnt_new; p0 = cnt_perr; f0 = cnt_ferr;
        send_frame(d, flip, stop, glitch, 11, 1'b1);
        if (stop && !flip) exp_code = d;
        chk({tag, "_new"},  32'(cnt_new - n0),  32'(stop && !flip));
        chk({tag, "_perr"}, 32'(cnt_perr - p0), 32'(stop && flip));
        chk({tag, "_ferr"}, 32'(cnt_ferr - f0), 32'(!stop));
        chk({tag, "_code"}, 32'(code), 32'(exp_code));
    endtask

    initial begin
        int n0, p0, f0;
        logic [7:0] rd;
        bit rflip, rstop;

        wait_cyc(5);
        chk("reset_out", 32'({code, new_code, parity_err, frame_err}), 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        run_frame(8'h1C, 1'b0, 1'b1, 0, "clean_1c");
        run_frame(8'hF0, 1'b0, 1'b1, 0, "b2b_f0");
        run_frame(8'h1C, 1'b0, 1'b1, 0, "b2b_1c");
        run_frame(8'h5A, 1'b1, 1'b1, 0, "par_5a");
        run_frame(8'h29, 1'b0, 1'b0, 0, "stop_29");
        run_frame(8'h76, 1'b0, 1'b1, FL - 1, "glitch_short");

        // A glitch of full filter length must register as an edge and spoil the frame
        n0 = cnt_new; p0 = cnt_perr; f0 = cnt_ferr;
        send_frame(8'h76, 1'b0, 1'b1, FL, 11, 1'b0);
        chk("glitch_long", 32'((cnt_new - n0 == 1) && (cnt_perr == p0) && (cnt_ferr == f0) && (code == 8'h76)), 32'd0);
        wait_cyc(TO + 10);
        exp_code = code;

        // Stall after four data bits: exactly one watchdog frame_err
        n0 = cnt_new; p0 = cnt_perr; f0 = cnt_ferr;
        send_frame(8'h33, 1'b0, 1'b1, 0, 5, 1'b0);
        wait_cyc(TO + 10);
        chk("stall_ferr", 32'(cnt_ferr - f0), 32'd1);
        chk("stall_other", 32'((cnt_new - n0) + (cnt_perr - p0)), 32'd0);
        run_frame(8'h5A, 1'b0, 1'b1, 0, "after_stall");

        // Reset mid-frame drops the partial frame
        send_frame(8'h44, 1'b0, 1'b1, 0, 4, 1'b0);
        rst_n = 1'b0;
        wait_cyc(3);
        chk("midreset_out", 32'({code, new_code, parity_err, frame_err}), 32'd0);
        exp_code = 8'h00;
        rst_n = 1'b1;
        wait_cyc(5);
        run_frame(8'hA5, 1'b0, 1'b1, 0, "after_reset");

        for (int i = 0; i < 12; i++) begin
            rd    = 8'($urandom);
            rflip = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 3) != 0);
            run_frame(rd, rflip, rstop, 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
